// File: rtl/m_ext_pkg.sv
// m_ext_pkg: shared widths, func3 codes and FSM encoding for the M-extension divider
package m_ext_pkg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // two's complement negate when n is set, modulo 2^XLEN
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring iteration on {rem,quo} against the divisor
module div_step
    import m_ext_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] sh;
    logic [XLEN:0] trial;
    logic          ge;

    // the shifted remainder can reach XLEN+1 bits, so compare and subtract at that width
    assign sh    = {rem_i, quo_i[XLEN-1]};
    assign ge    = sh >= {1'b0, div_i};
    assign trial = sh - {1'b0, div_i};
    assign rem_o = ge ? trial[XLEN-1:0] : sh[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], ge};
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIV/DIVU/REM/REMU unit with pipeline stall request
module div_sequencer
    import m_ext_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            stall_req,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [1:0]       f3_q, f3_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             go, sgn, dz, ovf, special, sa, sb, stall_c;
    logic [XLEN-1:0]  rem_s, quo_s, fin;

    assign go      = start & func3[2];
    assign sgn     = ~func3[0];
    assign dz      = op_b == '0;
    assign ovf     = sgn && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1;
    assign special = dz | ovf;
    assign sa      = sgn & op_a[XLEN-1];
    assign sb      = sgn & op_b[XLEN-1];

    div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (rem_s),
        .quo_o (quo_s)
    );

    // sign latches are only ever set for signed ops, so no func3 gating is needed here
    assign fin = f3_q[1] ? cond_neg(rem_q, sa_q) : cond_neg(quo_q, sa_q ^ sb_q);

    assign busy      = state_q != S_IDLE;
    assign result    = (state_q == S_DONE) ? fin : res_q;
    assign stall_req = stall_c & rst;

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            f3_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            f3_q    <= f3_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
        end
    end

    // next state, datapath loads and strobes; kill overrides every state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        res_d        = res_q;
        f3_d         = f3_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        stall_c      = 1'b0;
        result_valid = 1'b0;
        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        f3_d = func3[1:0];
                        if (special) begin
                            state_d = S_DONE;
                            sa_d    = 1'b0;
                            sb_d    = 1'b0;
                            quo_d   = dz ? '1 : {1'b1, {(XLEN-1){1'b0}}};
                            rem_d   = dz ? op_a : '0;
                        end else begin
                            state_d = S_CALC;
                            stall_c = 1'b1;
                            sa_d    = sa;
                            sb_d    = sb;
                            cnt_d   = '0;
                            rem_d   = '0;
                            quo_d   = cond_neg(op_a, sa);
                            dvs_d   = cond_neg(op_b, sb);
                        end
                    end
                end
                S_CALC: begin
                    stall_c = 1'b1;
                    rem_d   = rem_s;
                    quo_d   = quo_s;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CNT_W'(XLEN-1)) ? S_DONE : S_CALC;
                end
                S_DONE: begin
                    result_valid = 1'b1;
                    res_d        = fin;
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: table-driven scoreboard bench for the divide sequencer
module tb_div_sequencer;
    import m_ext_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  func3 = 3'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        stall_req, busy, result_valid;
    logic [31:0] result;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb_q[$];
    logic        prev_rv = 1'b0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        sp;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    div_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .func3        (func3),
        .op_a         (op_a),
        .op_b         (op_b),
        .kill         (kill),
        .stall_req    (stall_req),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // scoreboard: every result strobe pops the oldest expected value
    always @(negedge clk) begin
        if (rst && result_valid) begin
            if (sb_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else chk("result", result, sb_q.pop_front());
            chk("valid_pulse", {31'b0, prev_rv}, 32'd0);
        end
        prev_rv = result_valid;
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic sp);
        int nst;
        int lat;
        @(posedge clk); #1;
        start = 1'b1; func3 = f3; op_a = a; op_b = b;
        sb_q.push_back(exp);
        @(negedge clk);
        nst = stall_req ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) chk("busy_after_start", {31'b0, busy}, 32'd1);
            if (result_valid) begin
                lat = i;
                break;
            end
            if (stall_req) nst++;
        end
        chk("latency", 32'(lat), sp ? 32'd1 : 32'd33);
        chk("stall_cycles", 32'(nst), sp ? 32'd0 : 32'd33);
    endtask

    initial begin
        tbl.push_back('{F3_DIVU, 32'd100,        32'd7,        32'd14,        1'b0});
        tbl.push_back('{F3_REMU, 32'd100,        32'd7,        32'd2,         1'b0});
        tbl.push_back('{F3_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 1'b0});
        tbl.push_back('{F3_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 1'b0});
        tbl.push_back('{F3_DIVU, 32'd5,          32'd0,        32'hFFFF_FFFF, 1'b1});
        tbl.push_back('{F3_REM,  32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFB, 1'b1});
        tbl.push_back('{F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        tbl.push_back('{F3_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        1'b1});
        tbl.push_back('{F3_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0});
        tbl.push_back('{F3_REM,  32'd7,          32'hFFFF_FFFE, 32'd1,        1'b0});
        tbl.push_back('{F3_DIVU, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 1'b0});
        tbl.push_back('{F3_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'd1,        1'b0});
        tbl.push_back('{F3_DIV,  32'h8000_0000,  32'd2,        32'hC000_0000, 1'b0});
        tbl.push_back('{F3_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0});
        tbl.push_back('{F3_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        1'b0});
        tbl.push_back('{F3_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0});

        start = 1'b1; func3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7;
        #12;
        chk("rst_stall", {31'b0, stall_req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, result_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        start = 1'b0;
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].sp);

        // kill ten cycles into a divide; nothing may come out of it
        @(posedge clk); #1;
        start = 1'b1; func3 = F3_DIVU; op_a = 32'hFFFF_FFFF; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(negedge clk);
        chk("kill_stall", {31'b0, stall_req}, 32'd0);
        chk("kill_valid", {31'b0, result_valid}, 32'd0);
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_idle", {31'b0, busy}, 32'd0);
        run_op(F3_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

        // kill and start together in IDLE stay idle
        @(posedge clk); #1;
        start = 1'b1; kill = 1'b1; func3 = F3_DIV; op_a = 32'd20; op_b = 32'd4;
        @(negedge clk);
        chk("kill_start_stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        @(negedge clk);
        chk("kill_start_idle", {31'b0, busy}, 32'd0);
        chk("result_hold", result, 32'd3);

        // asynchronous reset in the middle of CALC
        @(posedge clk); #1;
        start = 1'b1; func3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b0; start = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_stall", {31'b0, stall_req}, 32'd0);
        chk("arst_valid", {31'b0, result_valid}, 32'd0);
        chk("arst_result", result, 32'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        run_op(F3_DIVU, 32'd10, 32'd3, 32'd3, 1'b0);
        run_op(F3_REMU, 32'd10, 32'd3, 32'd1, 1'b0);
        @(negedge clk);
        chk("post_valid_low", {31'b0, result_valid}, 32'd0);
        chk("post_result_hold", result, 32'd1);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
